mips_single_cycle_soc: RTL and testbench

Self-contained single-cycle 32-bit MIPS subset processor with an instruction ROM and a data RAM. The ROM holds a fixed self-check program. The data-memory write bus is exposed so a bench can watch stores. It is the top of the CPU simulation hierarchy, and a correct core ends the program by storing 7 to byte address 84.

---
 rtl/mips_single_cycle_soc.sv | 139 +++++++++++++
 tb/tb_mips_single_cycle_soc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_single_cycle_soc.sv
// Single-cycle MIPS subset core with a fixed self-check program in ROM and a
// small data RAM. The data-RAM write bus is brought out so stores can be observed.
module mips_single_cycle_soc #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic [31:0] rs_val, rt_val, imm_ext, alu_y, wb_data, rd_data;
  logic        reg_we, is_sw, is_lw;
  logic [IA_W-1:0] imem_idx;
  logic [DA_W-1:0] dmem_idx;

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  // RAM starts zeroed at configuration and is deliberately left alone by reset.
  logic [31:0] dmem_q [DMEM_WORDS] = '{default: '0};

  assign imem_idx = pc_q[IA_W+1:2];

  always_comb begin
    instr = 32'h0000_0000;
    case (int'(imem_idx))
      0:  instr = 32'h2002_0005;
      1:  instr = 32'h2003_000c;
      2:  instr = 32'h2067_fff7;
      3:  instr = 32'h00e2_2025;
      4:  instr = 32'h0064_2824;
      5:  instr = 32'h00a4_2820;
      6:  instr = 32'h10a7_000a;
      7:  instr = 32'h0064_202a;
      8:  instr = 32'h1080_0001;
      9:  instr = 32'h2005_0000;
      10: instr = 32'h00e2_202a;
      11: instr = 32'h0085_3820;
      12: instr = 32'h00e2_3822;
      13: instr = 32'hac67_0044;
      14: instr = 32'h8c02_0050;
      15: instr = 32'h0800_0011;
      16: instr = 32'h2002_0001;
      17: instr = 32'hac02_0054;
      default: instr = 32'h0000_0000;
    endcase
  end

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_ext  = {{16{instr[15]}}, instr[15:0]};
  assign pc_plus4 = pc_q + 32'd4;
  assign rs_val   = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  always_comb begin
    alu_y  = 32'h0;
    reg_we = 1'b0;
    wa     = rd;
    is_sw  = 1'b0;
    is_lw  = 1'b0;
    pc_d   = pc_plus4;
    case (op)
      6'h00: begin
        reg_we = 1'b1;
        case (funct)
          6'h20:   alu_y = rs_val + rt_val;
          6'h22:   alu_y = rs_val - rt_val;
          6'h24:   alu_y = rs_val & rt_val;
          6'h25:   alu_y = rs_val | rt_val;
          6'h2A:   alu_y = {31'b0, $signed(rs_val) < $signed(rt_val)};
          default: reg_we = 1'b0;
        endcase
      end
      6'h08: begin
        alu_y  = rs_val + imm_ext;
        reg_we = 1'b1;
        wa     = rt;
      end
      6'h23: begin
        alu_y  = rs_val + imm_ext;
        reg_we = 1'b1;
        wa     = rt;
        is_lw  = 1'b1;
      end
      6'h2B: begin
        alu_y = rs_val + imm_ext;
        is_sw = 1'b1;
      end
      6'h04: begin
        alu_y = rs_val - rt_val;
        if (alu_y == 32'h0) pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
      end
      6'h02: pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  // Load data comes straight from the RAM array so lw completes in one cycle.
  assign dmem_idx = alu_y[DA_W+1:2];
  assign rd_data  = dmem_q[dmem_idx];
  assign wb_data  = is_lw ? rd_data : alu_y;

  always_comb begin
    rf_d = rf_q;
    if (reg_we && (wa != 5'd0)) rf_d[wa] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memwrite) dmem_q[dmem_idx] <= writedata;
  end

  assign writedata = rt_val;
  assign dataadr   = alu_y;
  assign memwrite  = is_sw & rst;

endmodule

// File: tb/tb_mips_single_cycle_soc.sv
// Bench for mips_single_cycle_soc: fixed program trace table, mid-program reset
// sequence, then random reset pulses checked against an ISA-level model.
module tb_mips_single_cycle_soc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] writedata, dataadr;
  logic        memwrite;

  mips_single_cycle_soc dut (
    .clk       (clk),
    .rst       (rst),
    .writedata (writedata),
    .dataadr   (dataadr),
    .memwrite  (memwrite)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  logic [31:0] prog  [64];
  logic [31:0] m_rf  [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } reg_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
  } store_t;

  vec_t   tbl [17];
  reg_t   regs [7];
  store_t stores [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  // Architectural effect of one clock edge, from the instruction-set rules.
  task automatic model_edge(input logic r);
    logic [31:0] ins, a, b, imm, nxt;
    int t, d, s;
    if (!r) begin
      m_pc = 32'h0;
      foreach (m_rf[i]) m_rf[i] = 32'h0;
      return;
    end
    ins = prog[(m_pc / 4) % 64];
    s   = int'(ins[25:21]);
    t   = int'(ins[20:16]);
    d   = int'(ins[15:11]);
    a   = m_rf[s];
    b   = m_rf[t];
    imm = {{16{ins[15]}}, ins[15:0]};
    nxt = m_pc + 4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: m_rf[d] = a + b;
        6'h22: m_rf[d] = a - b;
        6'h24: m_rf[d] = a & b;
        6'h25: m_rf[d] = a | b;
        6'h2A: m_rf[d] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: ;
      endcase
      6'h08: m_rf[t] = a + imm;
      6'h23: m_rf[t] = m_mem[((a + imm) / 4) % 64];
      6'h2B: m_mem[((a + imm) / 4) % 64] = b;
      6'h04: if (a == b) nxt = nxt + imm * 4;
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_rf[0] = 32'h0;
    m_pc = nxt;
  endtask

  task automatic predict(output logic mw, output logic [31:0] adr, output logic [31:0] wd);
    logic [31:0] ins;
    ins = prog[(m_pc / 4) % 64];
    wd  = m_rf[ins[20:16]];
    adr = m_rf[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
    mw  = rst && (ins[31:26] == 6'h2B);
  endtask

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    model_edge(r);
    cycle++;
    #1;
  endtask

  task automatic cmp_outputs();
    logic mw;
    logic [31:0] adr, wd;
    int r;
    predict(mw, adr, wd);
    check("memwrite", memwrite, mw);
    check("writedata", writedata, wd);
    if (mw) check("dataadr", dataadr, adr);
    check("pc", dut.pc_q, m_pc);
    r = $urandom_range(1, 31);
    check("regfile", dut.rf_q[r], m_rf[r]);
  endtask

  initial begin
    int guard;
    int nonzero;
    logic [31:0] pcs [17];

    foreach (prog[i]) prog[i] = 32'h0;
    prog[0]  = 32'h20020005; prog[1]  = 32'h2003000c; prog[2]  = 32'h2067fff7;
    prog[3]  = 32'h00e22025; prog[4]  = 32'h00642824; prog[5]  = 32'h00a42820;
    prog[6]  = 32'h10a7000a; prog[7]  = 32'h0064202a; prog[8]  = 32'h10800001;
    prog[9]  = 32'h20050000; prog[10] = 32'h00e2202a; prog[11] = 32'h00853820;
    prog[12] = 32'h00e23822; prog[13] = 32'hac670044; prog[14] = 32'h8c020050;
    prog[15] = 32'h08000011; prog[16] = 32'h20020001; prog[17] = 32'hac020054;
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    foreach (m_rf[i])  m_rf[i]  = 32'h0;

    pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
            32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h44, 32'h48};
    foreach (tbl[i]) tbl[i] = '{pcs[i], 1'b0, 32'h0, 32'h0};
    tbl[12] = '{32'h34, 1'b1, 32'd80, 32'd7};
    tbl[15] = '{32'h44, 1'b1, 32'd84, 32'd7};
    regs = '{'{1, 32'd0}, '{2, 32'd7}, '{3, 32'd12}, '{4, 32'd1},
             '{5, 32'd11}, '{6, 32'd0}, '{7, 32'd7}};

    // Reset held low for two edges.
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_memwrite", memwrite, 1'b0);
      check("rst_pc", dut.pc_q, 32'h0);
    end
    rst = 1'b1;

    // Golden program trace.
    for (int k = 0; k < 17; k++) begin
      if (k > 0) tick();
      $display("[TB] step %0d pc=%h memwrite=%0b adr=%0d data=%0d",
               k, dut.pc_q, memwrite, dataadr, writedata);
      check("trace_pc", dut.pc_q, tbl[k].pc);
      check("trace_memwrite", memwrite, tbl[k].mw);
      if (tbl[k].mw) begin
        check("trace_dataadr", dataadr, tbl[k].adr);
        check("trace_writedata", writedata, tbl[k].wd);
      end
      cmp_outputs();
    end
    foreach (regs[i]) check($sformatf("reg%0d", regs[i].idx), dut.rf_q[regs[i].idx], regs[i].val);

    // NOP region: no store and PC advances by 4.
    tick();
    check("nop_pc", dut.pc_q, 32'h4C);
    check("nop_memwrite", memwrite, 1'b0);
    cmp_outputs();

    // Restart, then reset in the middle of the program while a store is current.
    rst = 1'b0;
    tick();
    cmp_outputs();
    rst = 1'b1;
    guard = 0;
    while (dut.pc_q !== 32'h34 && guard < 30) begin
      tick();
      cmp_outputs();
      guard++;
    end
    check("reach_sw", dut.pc_q, 32'h34);
    check("sw_memwrite", memwrite, 1'b1);
    rst = 1'b0;
    #1;
    check("mw_forced_low", memwrite, 1'b0);
    tick();
    check("midrst_pc", dut.pc_q, 32'h0);
    nonzero = 0;
    for (int i = 1; i < 32; i++) if (dut.rf_q[i] !== 32'h0) nonzero++;
    check("rf_cleared", nonzero, 0);
    rst = 1'b1;

    // Rerun: exactly two stores, 80/7 then 84/7, before PC reaches 0x48.
    stores.delete();
    guard = 0;
    while (guard < 40) begin
      if (memwrite === 1'b1) begin
        stores.push_back('{dataadr, writedata});
        $display("[TB] store adr=%0d data=%0d pc=%h", dataadr, writedata, dut.pc_q);
      end
      if (dut.pc_q === 32'h48) break;
      tick();
      cmp_outputs();
      guard++;
    end
    check("rerun_done", dut.pc_q, 32'h48);
    check("store_count", stores.size(), 2);
    if (stores.size() >= 2) begin
      check("store0_adr", stores[0].adr, 32'd80);
      check("store0_data", stores[0].wd, 32'd7);
      check("store1_adr", stores[1].adr, 32'd84);
      check("store1_data", stores[1].wd, 32'd7);
    end

    // Random reset pulses against the model, across PC wrap-around.
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 19) != 0);
      tick();
      cmp_outputs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
